// File: rtl/bn_relu_seq_ctrl_if.sv
// Handshake and control bundle between the BN/ReLU sequencer and its neighbours.
// Master drives beats/config in; slave is the sequencer.
interface bn_relu_seq_ctrl_if #(
    parameter int CH_W = 2
);
    logic            start;
    logic            cfg_relu_en;
    logic            in_valid;
    logic            in_ready;
    logic [CH_W-1:0] param_addr;
    logic            pipe_en;
    logic            relu_en;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;
    logic            busy;
    logic            done;

    modport master (
        output start, cfg_relu_en, in_valid, out_ready,
        input  in_ready, param_addr, pipe_en, relu_en,
        input  out_valid, out_last, busy, done
    );

    modport slave (
        input  start, cfg_relu_en, in_valid, out_ready,
        output in_ready, param_addr, pipe_en, relu_en,
        output out_valid, out_last, busy, done
    );
endinterface

// File: rtl/bn_relu_seq_ctrl.sv
// BN/ReLU post-processing sequencer: frame counters, parameter ROM address,
// pipeline enable and in-flight valid/last tracking through the fixed-latency pipe.
module bn_relu_seq_ctrl #(
    parameter int IN_CHANNELS = 4,
    parameter int IMAGE_WIDTH = 128,
    parameter int NUM_ROWS    = 128,
    parameter int PIPE_LAT    = 3,
    parameter int CH_W        = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bn_relu_seq_ctrl_if.slave    bus
);
    localparam int PX_W  = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [PIPE_LAT-1:0] TOP_ONLY = PIPE_LAT'(1) << (PIPE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CH_W-1:0]    ch_cnt;
    logic [PX_W-1:0]    px_cnt;
    logic [ROW_W-1:0]   row_cnt;
    logic [PIPE_LAT-1:0] vld;
    logic [PIPE_LAT-1:0] lst;
    logic               relu_q;
    logic               stall;
    logic               accept;
    logic               ch_wrap;
    logic               px_wrap;
    logic               row_wrap;
    logic               last_beat;
    logic               drain_ok;

    assign stall     = vld[PIPE_LAT-1] & ~bus.out_ready;
    assign accept    = bus.in_valid & bus.in_ready;
    assign ch_wrap   = (ch_cnt == CH_W'(IN_CHANNELS - 1));
    assign px_wrap   = (px_cnt == PX_W'(IMAGE_WIDTH - 1));
    assign row_wrap  = (row_cnt == ROW_W'(NUM_ROWS - 1));
    assign last_beat = accept & ch_wrap & px_wrap & row_wrap;
    // Empty pipe, or only the final stage left and it leaves this cycle.
    assign drain_ok  = (vld == '0) | ((vld == TOP_ONLY) & bus.out_ready);

    assign bus.in_ready   = (state == RUN) & ~stall;
    assign bus.param_addr = (state == RUN) ? ch_cnt : '0;
    assign bus.pipe_en    = ~stall;
    assign bus.relu_en    = relu_q;
    assign bus.out_valid  = vld[PIPE_LAT-1];
    assign bus.out_last   = lst[PIPE_LAT-1] & vld[PIPE_LAT-1];
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_beat) state_nxt = DRAIN;
            DRAIN:   if (drain_ok) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame position counters and per-frame ReLU enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt  <= '0;
            px_cnt  <= '0;
            row_cnt <= '0;
            relu_q  <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            ch_cnt  <= '0;
            px_cnt  <= '0;
            row_cnt <= '0;
            relu_q  <= bus.cfg_relu_en;
        end else begin
            if (state == DONE) begin
                relu_q <= 1'b0;
            end
            if (accept) begin
                ch_cnt <= ch_wrap ? '0 : ch_cnt + 1'b1;
                if (ch_wrap) begin
                    px_cnt <= px_wrap ? '0 : px_cnt + 1'b1;
                    if (px_wrap) begin
                        row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
                    end
                end
            end
        end
    end

    // In-flight valid and last-beat tracking; everything holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            lst <= '0;
        end else if (!stall) begin
            vld <= (vld << 1) | PIPE_LAT'(accept);
            lst <= (lst << 1) | PIPE_LAT'(last_beat);
        end
    end
endmodule

// File: tb/tb_bn_relu_seq_ctrl.sv
// Bench for bn_relu_seq_ctrl: randomized frames checked cycle by cycle
// against a queue-based model of beats travelling through the pipe.
module tb_bn_relu_seq_ctrl;
    localparam int IC    = 4;
    localparam int IW    = 4;
    localparam int NR    = 2;
    localparam int PL    = 3;
    localparam int CW    = 2;
    localparam int TOTAL = IC * IW * NR;
    localparam int VW    = CW + 7;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bn_relu_seq_ctrl_if #(.CH_W(CW)) bus ();

    bn_relu_seq_ctrl #(
        .IN_CHANNELS (IC),
        .IMAGE_WIDTH (IW),
        .NUM_ROWS    (NR),
        .PIPE_LAT    (PL),
        .CH_W        (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests;
    int n_fail;
    int cyc;

    // model state
    bit m_active;
    bit m_donep;
    bit m_relu;
    int m_acc;
    int m_emit;
    int q_cnt[$];
    int q_idx[$];

    // values of the current cycle
    bit d_st, d_cfg, d_iv, d_or, d_rst;
    bit e_stall, e_acc, e_hs;
    logic [VW-1:0] obs;
    logic [VW-1:0] expv;

    // Drive one cycle of inputs, then sample DUT and form model expectation.
    task automatic drive(input bit st, input bit cfg, input bit iv,
                         input bit ordy, input bit r);
        bit ov;
        bit run;
        bit lastb;
        int pa;
        @(negedge clk);
        bus.start       = st;
        bus.cfg_relu_en = cfg;
        bus.in_valid    = iv;
        bus.out_ready   = ordy;
        rst             = r;
        d_st = st; d_cfg = cfg; d_iv = iv; d_or = ordy; d_rst = r;
        #1;
        ov      = (q_cnt.size() > 0) && (q_cnt[0] == 0);
        lastb   = ov && (q_idx[0] == TOTAL - 1);
        e_stall = ov && !ordy;
        run     = m_active && !m_donep && (m_acc < TOTAL);
        e_acc   = iv && run && !e_stall;
        e_hs    = ov && ordy;
        pa      = run ? (m_acc % IC) : 0;
        expv = {run && !e_stall, CW'(pa), !e_stall, m_active && m_relu,
                ov, lastb, m_active, m_donep};
        obs  = {bus.in_ready, bus.param_addr, bus.pipe_en, bus.relu_en,
                bus.out_valid, bus.out_last, bus.busy, bus.done};
    endtask

    // Advance the clock and the model by one edge.
    task automatic tick();
        bit was_idle;
        @(posedge clk);
        cyc++;
        was_idle = !m_active;
        if (d_rst) begin
            m_active = 0; m_donep = 0; m_relu = 0;
            m_acc = 0; m_emit = 0;
            q_cnt.delete(); q_idx.delete();
        end else begin
            if (m_donep) begin
                m_active = 0; m_donep = 0; m_relu = 0;
            end else if (!e_stall) begin
                if (e_hs) begin
                    void'(q_cnt.pop_front());
                    void'(q_idx.pop_front());
                    m_emit++;
                    if (m_emit == TOTAL) m_donep = 1;
                end
                foreach (q_cnt[i]) if (q_cnt[i] > 0) q_cnt[i]--;
                if (e_acc) begin
                    q_cnt.push_back(PL - 1);
                    q_idx.push_back(m_acc);
                    m_acc++;
                end
            end
            if (was_idle && d_st) begin
                m_active = 1; m_relu = d_cfg; m_acc = 0; m_emit = 0;
            end
        end
    endtask

    task automatic test_reset();
        logic [VW-1:0] rst_v;
        rst_v = {1'b0, CW'(0), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1, 1);
            tick();
        end
        drive(0, 0, 1, 1, 0);
        n_tests++;
        if (obs !== rst_v) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", obs, rst_v);
        end
        tick();
    endtask

    task automatic test_streaming();
        int acc_n, out_n, last_at, n_last, done_n, t_acc, t_acc_end, t_ov;
        bit post, lb;
        acc_n = 0; out_n = 0; last_at = 0; n_last = 0; done_n = 0;
        t_acc = -1; t_acc_end = -1; t_ov = -1; post = 0; lb = 1;
        drive(1, 1, 0, 1, 0);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL stream_start: got %b want %b", obs, expv);
        end
        tick();
        for (int c = 0; c < 300; c++) begin
            drive(0, 0, 1, 1, 0);
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL stream cyc %0d: got %b want %b", cyc, obs, expv);
            end
            if (acc_n == 16) begin
                n_tests++;
                if (bus.in_ready !== 1'b1 || bus.param_addr !== CW'(0)) begin
                    n_fail++;
                    $display("FAIL wrap_16: in_ready %b addr %0d want 1 0",
                             bus.in_ready, bus.param_addr);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                acc_n++;
                if (t_acc < 0) t_acc = cyc;
                t_acc_end = cyc;
            end
            if (bus.out_valid && t_ov < 0) t_ov = cyc;
            if (bus.out_valid && bus.out_ready) begin
                out_n++;
                if (bus.out_last) begin last_at = out_n; n_last++; end
            end
            if (bus.done) done_n++;
            lb = bus.busy;
            tick();
            if (post) break;
            post = (done_n > 0);
        end
        n_tests++;
        if (acc_n !== TOTAL || out_n !== TOTAL) begin
            n_fail++;
            $display("FAIL stream_count: acc %0d out %0d want %0d", acc_n, out_n, TOTAL);
        end
        n_tests++;
        if (t_acc_end - t_acc !== TOTAL - 1) begin
            n_fail++;
            $display("FAIL stream_rate: span %0d want %0d", t_acc_end - t_acc, TOTAL - 1);
        end
        n_tests++;
        if (t_ov - t_acc !== PL) begin
            n_fail++;
            $display("FAIL stream_latency: got %0d want %0d", t_ov - t_acc, PL);
        end
        n_tests++;
        if (last_at !== TOTAL || n_last !== 1) begin
            n_fail++;
            $display("FAIL stream_last: at %0d n %0d want %0d 1", last_at, n_last, TOTAL);
        end
        n_tests++;
        if (done_n !== 1 || lb !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_done: pulses %0d busy %b want 1 0", done_n, lb);
        end
    endtask

    task automatic test_backpressure();
        int out_n, last_at, done_n, stall_bad;
        bit post, ordy;
        out_n = 0; last_at = 0; done_n = 0; stall_bad = 0; post = 0;
        drive(1, 1, 0, 1, 0);
        tick();
        for (int c = 0; c < 300; c++) begin
            ordy = !(c >= 12 && c < 17);
            drive(0, 0, 1, ordy, 0);
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL bp cyc %0d: got %b want %b", cyc, obs, expv);
            end
            if (!ordy && (bus.in_ready || bus.pipe_en)) stall_bad++;
            if (bus.out_valid && bus.out_ready) begin
                out_n++;
                if (bus.out_last) last_at = out_n;
            end
            if (bus.done) done_n++;
            tick();
            if (post) break;
            post = (done_n > 0);
        end
        n_tests++;
        if (stall_bad !== 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d stalled cycles with in_ready/pipe_en high, want 0", stall_bad);
        end
        n_tests++;
        if (out_n !== TOTAL || last_at !== TOTAL || done_n !== 1) begin
            n_fail++;
            $display("FAIL bp_frame: out %0d last %0d done %0d want %0d %0d 1",
                     out_n, last_at, done_n, TOTAL, TOTAL);
        end
    endtask

    task automatic test_bubbles();
        int acc_n, out_n, done_n;
        bit post;
        acc_n = 0; out_n = 0; done_n = 0; post = 0;
        drive(1, 1, 0, 1, 0);
        tick();
        for (int c = 0; c < 300; c++) begin
            drive(0, 0, (c % 2) == 0, 1, 0);
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL bubble cyc %0d: got %b want %b", cyc, obs, expv);
            end
            if (bus.in_valid && bus.in_ready) acc_n++;
            if (bus.out_valid && bus.out_ready) out_n++;
            if (bus.done) done_n++;
            tick();
            if (post) break;
            post = (done_n > 0);
        end
        n_tests++;
        if (acc_n !== TOTAL || out_n !== TOTAL || done_n !== 1) begin
            n_fail++;
            $display("FAIL bubble_frame: acc %0d out %0d done %0d want %0d %0d 1",
                     acc_n, out_n, done_n, TOTAL, TOTAL);
        end
    endtask

    task automatic test_reset_mid();
        int acc_n, out_n, done_n;
        bit post;
        acc_n = 0; done_n = 0;
        drive(1, 1, 0, 1, 0);
        tick();
        for (int c = 0; c < 50 && acc_n < 10; c++) begin
            drive(0, 0, 1, 1, 0);
            if (bus.in_valid && bus.in_ready) acc_n++;
            tick();
        end
        drive(0, 0, 1, 1, 1);
        tick();
        drive(0, 0, 1, 1, 0);
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_flush: out_valid %b busy %b want 0 0",
                     bus.out_valid, bus.busy);
        end
        tick();
        for (int c = 0; c < 8; c++) begin
            drive(0, 0, 1, 1, 0);
            if (bus.done) done_n++;
            tick();
        end
        n_tests++;
        if (done_n !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_nodone: pulses %0d want 0", done_n);
        end
        acc_n = 0; out_n = 0; done_n = 0; post = 0;
        drive(1, 1, 0, 1, 0);
        tick();
        for (int c = 0; c < 300; c++) begin
            drive(0, 0, 1, 1, 0);
            n_tests++;
            if (obs !== expv) begin
                n_fail++;
                $display("FAIL rst_mid_refr cyc %0d: got %b want %b", cyc, obs, expv);
            end
            if (bus.in_valid && bus.in_ready) acc_n++;
            if (bus.out_valid && bus.out_ready) out_n++;
            if (bus.done) done_n++;
            tick();
            if (post) break;
            post = (done_n > 0);
        end
        n_tests++;
        if (acc_n !== TOTAL || out_n !== TOTAL || done_n !== 1) begin
            n_fail++;
            $display("FAIL rst_mid_frame: acc %0d out %0d done %0d want %0d %0d 1",
                     acc_n, out_n, done_n, TOTAL, TOTAL);
        end
    endtask

    task automatic test_ignored_start();
        int relu_bad, done_n;
        bit post;
        for (int f = 0; f < 2; f++) begin
            relu_bad = 0; done_n = 0; post = 0;
            drive(1, f == 0, 0, 1, 0);
            tick();
            for (int c = 0; c < 300; c++) begin
                drive(c == 5 || c == 9, f != 0, $urandom_range(0, 3) != 0, 1, 0);
                n_tests++;
                if (obs !== expv) begin
                    n_fail++;
                    $display("FAIL ign f%0d cyc %0d: got %b want %b", f, cyc, obs, expv);
                end
                if (bus.busy && bus.relu_en !== (f == 0)) relu_bad++;
                if (bus.done) done_n++;
                tick();
                if (post) break;
                post = (done_n > 0);
            end
            n_tests++;
            if (relu_bad !== 0 || done_n !== 1) begin
                n_fail++;
                $display("FAIL ign_frame%0d: relu_bad %0d done %0d want 0 1", f, relu_bad, done_n);
            end
        end
        drive(1, 1, 1, 1, 1);
        tick();
        drive(0, 0, 1, 1, 0);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL start_with_rst: busy %b in_ready %b want 0 0", bus.busy, bus.in_ready);
        end
        tick();
    endtask

    task automatic test_random();
        int out_n, done_n;
        bit post;
        for (int f = 0; f < 4; f++) begin
            out_n = 0; done_n = 0; post = 0;
            drive(1, 1'($urandom), 0, 1'($urandom), 0);
            tick();
            for (int c = 0; c < 600; c++) begin
                drive(m_active && !m_donep && ($urandom_range(0, 7) == 0),
                      1'($urandom), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 2) != 0, 0);
                n_tests++;
                if (obs !== expv) begin
                    n_fail++;
                    $display("FAIL rand f%0d cyc %0d: got %b want %b", f, cyc, obs, expv);
                end
                if (bus.out_valid && bus.out_ready) out_n++;
                if (bus.done) done_n++;
                tick();
                if (post) break;
                post = (done_n > 0);
            end
            n_tests++;
            if (out_n !== TOTAL || done_n !== 1) begin
                n_fail++;
                $display("FAIL rand_frame%0d: out %0d done %0d want %0d 1", f, out_n, done_n, TOTAL);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.cfg_relu_en = 1'b0;
        bus.in_valid    = 1'b0;
        bus.out_ready   = 1'b1;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_ignored_start();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bn_relu_seq_ctrl.md
Name: bn_relu_seq_ctrl

Overview:
- Sequencer for the batch-norm/ReLU post-processing stage behind the conv engine.
- Accepts a frame of conv results with a valid/ready handshake and emits the per-channel BN parameter address.
- Drives the datapath pipeline enable and ReLU enable, tracks in-flight beats through the fixed-latency BN→reg→ReLU pipe, and flags last-beat/done.
- Input beats are channel-interleaved: for each pixel, channels 0..IN_CHANNELS-1; pixels row-major.

Parameters:
- IN_CHANNELS, 4, channels per pixel; also the parameter-ROM depth.
- IMAGE_WIDTH, 128, pixels per row.
- NUM_ROWS, 128, rows per frame.
- PIPE_LAT, 3, datapath stages from accepted beat to ReLU output, ≥1.
- CH_W, $clog2(IN_CHANNELS) (min 1), channel index width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  frame start pulse; honoured only in IDLE
- cfg_relu_en  in  1  ReLU enable for the frame, sampled on accepted start
- in_valid  in  1  conv result beat available
- in_ready  out  1  controller/datapath accepts beat
- param_addr  out  CH_W  BN scale/shift ROM address (channel of accepted beat)
- pipe_en  out  1  global datapath stage enable (0 = hold all stages)
- relu_en  out  1  ReLU enable to datapath
- out_valid  out  1  datapath output beat valid
- out_ready  in  1  downstream accepts beat
- out_last  out  1  qualifies final beat of frame at output
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Reset (sync, any state, incl. mid-frame): state=IDLE; all counters 0; valid and last shift registers cleared.
  - Outputs: in_ready=0, param_addr=0, pipe_en=1, relu_en=0, out_valid=0, out_last=0, busy=0, done=0.
  - In-flight beats are discarded.
- Stall: stall = out_valid & ~out_ready.
  - pipe_en = ~stall.
  - in_ready = (state==RUN) & ~stall.
  - Accept = in_valid & in_ready.
- States:
  - IDLE: start → RUN; latch relu_en = cfg_relu_en; clear ch_cnt, px_cnt, row_cnt.
  - RUN: on each accept, advance counters:
    - ch_cnt wraps IN_CHANNELS-1→0 and increments px_cnt.
    - px_cnt wraps IMAGE_WIDTH-1→0 and increments row_cnt.
    - The accept where ch_cnt=IN_CHANNELS-1, px_cnt=IMAGE_WIDTH-1, row_cnt=NUM_ROWS-1 is the last beat → DRAIN.
  - DRAIN: in_ready=0; when no valid bit is set in the pipe, or the only set bit is the final stage and it is handshaking this cycle (out_valid & out_ready) → DONE.
  - DONE: done=1 for exactly one cycle → IDLE; relu_en returns to 0.
- start while not IDLE: ignored. start with rst: rst wins.
- param_addr:
  - Combinational = ch_cnt in RUN, otherwise 0.
  - ROM has 1-cycle read latency, so scale/shift arrive aligned with stage 1 of the datapath.
- Valid tracking: PIPE_LAT-bit shift register vld.
  - When pipe_en=1: vld[0] ← accept, vld[k] ← vld[k-1].
  - When pipe_en=0: all bits hold.
  - out_valid = vld[PIPE_LAT-1].
  - Parallel shift register lst carries the last-beat flag; out_last = lst[PIPE_LAT-1] & out_valid.
- Latency: a beat accepted at cycle t appears as out_valid at t+PIPE_LAT, plus one cycle per stalled cycle.
- Throughput: 1 beat/cycle when out_ready is held 1.
- No beat is lost or duplicated under any in_valid/out_ready pattern.
- relu_en is constant for a whole frame.

Test Plan (IN_CHANNELS=4, IMAGE_WIDTH=4, NUM_ROWS=2, PIPE_LAT=3 unless noted):
- Streaming: reset, start with cfg_relu_en=1, in_valid=1 and out_ready=1 continuously → 32 accepts over 32 cycles.
  - param_addr sequence 0,1,2,3 repeated; first out_valid 3 cycles after the first accept.
  - out_last on the 32nd output; done pulses once on the cycle after the DONE transition; busy low afterwards.
- Backpressure: drop out_ready for 5 cycles mid-frame → in_ready=0 and pipe_en=0 throughout; vld frozen; total outputs still 32, in order; out_last still on beat 32.
- Bubbles: in_valid toggles 1,0,1,0 → counters advance only on accepts; param_addr correct per accepted beat; outputs separated by matching gaps.
- Boundary wrap: check ch_cnt 3→0 with px_cnt 3→0 and row_cnt increment on beat 16 → DRAIN entered only after beat 32, not beat 16.
- Reset mid-frame: assert rst after 10 accepts with 3 beats in flight → next cycle out_valid=0, busy=0, done never pulses; a fresh start then runs a full 32-beat frame correctly.
- Ignored start and ReLU config: pulse start during RUN → no counter reset. A second frame with cfg_relu_en=0 → relu_en=0 for that entire frame. start with rst high → stays IDLE.
